// File: rtl/shift_addsub_pipe.sv
// shift_addsub_pipe: two-stage pipelined A +/- (B >>> shift) with valid/ready stream and optional saturation
module shift_addsub_pipe #(
  parameter int WORD_WIDTH = 16,
  parameter int SHIFT_WIDTH = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             ALU_operation,
  input  logic                   dir,
  input  logic [WORD_WIDTH-1:0]  A,
  input  logic [WORD_WIDTH-1:0]  B,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  ALU_out,
  output logic                   overflow
);
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_NOP = 2'd2, OP_DIR = 2'd3;
  localparam logic [WORD_WIDTH-1:0] MAX_POS = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic [WORD_WIDTH-1:0] MIN_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  logic                  s1_valid;
  logic [1:0]            s1_op;
  logic [WORD_WIDTH-1:0] s1_a, s1_bs;
  logic                  adv1, adv2;
  logic [1:0]            op_res;
  logic [WORD_WIDTH-1:0] bs, res;
  logic [WORD_WIDTH:0]   a_ext, b_ext, sum;
  logic                  ovf;
  // handshake, DIR resolution, shifter and the one-bit-wider add/sub with saturation
  always_comb begin
    adv2 = !out_valid || out_ready;
    adv1 = !s1_valid || adv2;
    in_ready = adv1;
    op_res = ALU_operation == OP_DIR ? (dir ? OP_ADD : OP_SUB) : ALU_operation;
    bs = $signed(B) >>> shift;
    a_ext = {s1_a[WORD_WIDTH-1], s1_a};
    b_ext = {s1_bs[WORD_WIDTH-1], s1_bs};
    sum = s1_op == OP_ADD ? a_ext + b_ext : s1_op == OP_SUB ? a_ext - b_ext : a_ext;
    ovf = sum[WORD_WIDTH] ^ sum[WORD_WIDTH-1];
    res = (SATURATE && ovf) ? (sum[WORD_WIDTH] ? MIN_NEG : MAX_POS) : sum[WORD_WIDTH-1:0];
  end
  // stage 1: capture A, resolved op and shifted B when the stage can move
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_a     <= '0;
      s1_bs    <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_res;
        s1_a  <= A;
        s1_bs <= bs;
      end
    end
  end
  // stage 2: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALU_out   <= '0;
      overflow  <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ALU_out  <= res;
        overflow <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_shift_addsub_pipe.sv
// tb_shift_addsub_pipe: randomized and directed scoreboard bench for shift_addsub_pipe (saturating and wrapping builds)
module tb_shift_addsub_pipe;
  typedef struct {
    logic [15:0] s;
    logic [15:0] w;
    logic        o;
    int          c;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  ALU_operation = 2'd0;
  logic        dir = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [3:0]  shift = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, overflow;
  logic [15:0] ALU_out;
  logic        in_ready_w, out_valid_w, ovf_w;
  logic [15:0] alu_out_w;
  exp_t        q[$];
  exp_t        zero_e = '{16'h0, 16'h0, 1'b0, 0};
  int          total = 0, bad = 0, cyc = 0, emitted = 0, last_lat = -1;

  always #5 clk = ~clk;

  shift_addsub_pipe #(.WORD_WIDTH(16), .SHIFT_WIDTH(4), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_operation(ALU_operation), .dir(dir), .A(A), .B(B), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_out(ALU_out), .overflow(overflow));

  shift_addsub_pipe #(.WORD_WIDTH(16), .SHIFT_WIDTH(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .ALU_operation(ALU_operation), .dir(dir), .A(A), .B(B), .shift(shift),
    .out_valid(out_valid_w), .out_ready(out_ready), .ALU_out(alu_out_w), .overflow(ovf_w));

  function automatic exp_t model(input logic [1:0] op, input logic d, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    exp_t e;
    int av, bv, s;
    av = int'($signed(a));
    bv = int'($signed(b));
    bv = bv >>> sh;
    if (op == 2'd0 || (op == 2'd3 && d)) s = av + bv;
    else if (op == 2'd1 || op == 2'd3) s = av - bv;
    else s = av;
    e.o = (s > 32767) || (s < -32768);
    e.w = s[15:0];
    e.s = e.o ? (s > 0 ? 16'h7FFF : 16'h8000) : s[15:0];
    e.c = 0;
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [1:0] op, input logic d, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic ordy, input exp_t e, output logic acc, output logic rdy);
    @(negedge clk);
    in_valid = v; ALU_operation = op; dir = d; A = a; B = b; shift = sh; out_ready = ordy;
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    total++;
    if (out_valid_w !== out_valid || in_ready_w !== in_ready) begin
      bad++;
      $display("FAIL handshake_match: sat v/r=%b/%b wrap v/r=%b/%b", out_valid, in_ready, out_valid_w, in_ready_w);
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_out: out_valid=1 ALU_out=%h with no beat expected", ALU_out);
      end else begin
        total++;
        if (ALU_out !== q[0].s || overflow !== q[0].o) begin
          bad++;
          $display("FAIL sat_result: got %h ovf=%b want %h ovf=%b", ALU_out, overflow, q[0].s, q[0].o);
        end
        total++;
        if (alu_out_w !== q[0].w || ovf_w !== q[0].o) begin
          bad++;
          $display("FAIL wrap_result: got %h ovf=%b want %h ovf=%b", alu_out_w, ovf_w, q[0].w, q[0].o);
        end
        if (out_ready) begin
          last_lat = cyc - q[0].c;
          void'(q.pop_front());
          emitted++;
        end
      end
    end
    if (acc) begin
      e.c = cyc;
      q.push_back(e);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain();
    logic acc, rdy;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, zero_e, acc, rdy);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats still pending, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || ALU_out !== 16'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: v=%b out=%h ovf=%b rdy=%b want 0 0000 0 1", out_valid, ALU_out, overflow, in_ready);
    end
    total++;
    if (out_valid_w !== 1'b0 || alu_out_w !== 16'h0 || ovf_w !== 1'b0 || in_ready_w !== 1'b1) begin
      bad++;
      $display("FAIL reset_state_wrap: v=%b out=%h ovf=%b rdy=%b want 0 0000 0 1", out_valid_w, alu_out_w, ovf_w, in_ready_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic acc, rdy;
    cycle(1'b1, 2'd0, 1'b0, 16'd16, 16'd32, 4'd1, 1'b1, '{16'd32, 16'd32, 1'b0, 0}, acc, rdy);
    drain();
    total++;
    if (last_lat !== 2) begin
      bad++;
      $display("FAIL latency: got %0d cycles want 2", last_lat);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops[9]  = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic        ds[9]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] as[9]   = '{16'd16, 16'd45, 16'd100, 16'd100, 16'hFFFF, 16'h7FF0, 16'h8000, 16'd10, 16'd10};
    logic [15:0] bs[9]   = '{16'd32, 16'd90, 16'd64, 16'd64, 16'h1234, 16'h0020, 16'h0001, 16'hFFFC, 16'd4};
    logic [3:0]  shs[9]  = '{4'd1, 4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15};
    logic [15:0] xs[9]   = '{16'd32, 16'hFFD3, 16'd116, 16'd84, 16'hFFFF, 16'h7FFF, 16'h8000, 16'd9, 16'd10};
    logic [15:0] xw[9]   = '{16'd32, 16'hFFD3, 16'd116, 16'd84, 16'hFFFF, 16'h8010, 16'h7FFF, 16'd9, 16'd10};
    logic        xo[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic acc, rdy;
    for (int i = 0; i < 9; i++)
      cycle(1'b1, ops[i], ds[i], as[i], bs[i], shs[i], 1'b1, '{xs[i], xw[i], xo[i], 0}, acc, rdy);
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc, rdy;
    logic [15:0] a, b;
    logic [3:0] sh;
    logic [1:0] op;
    logic d;
    int sent = 0, start = emitted;
    for (int i = 0; i < 40 && (sent < 6 || q.size() > 0); i++) begin
      a = 16'($urandom); b = 16'($urandom); sh = 4'($urandom); op = 2'($urandom); d = 1'($urandom);
      cycle(sent < 6, op, d, a, b, sh, !(i >= 3 && i <= 5), model(op, d, a, b, sh), acc, rdy);
      if (acc) sent++;
      if (i >= 3 && i <= 5) begin
        total++;
        if (rdy !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready: cycle %0d in_ready=%b want 0", i, rdy);
        end
      end
    end
    total++;
    if (sent != 6 || emitted - start != 6) begin
      bad++;
      $display("FAIL b2b_count: sent=%0d emitted=%0d want 6 6", sent, emitted - start);
    end
  endtask

  task automatic test_random();
    logic acc, rdy;
    logic [15:0] a, b;
    logic [3:0] sh;
    logic [1:0] op;
    logic d;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 16'h7FF0 : 16'h8008) : 16'($urandom);
      b = 16'($urandom);
      sh = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom);
      op = 2'($urandom); d = 1'($urandom);
      cycle(1'($urandom_range(3) != 0), op, d, a, b, sh, 1'($urandom_range(2) != 0), model(op, d, a, b, sh), acc, rdy);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    logic acc, rdy;
    int start;
    cycle(1'b1, 2'd0, 1'b0, 16'd1, 16'd2, 4'd0, 1'b0, model(2'd0, 1'b0, 16'd1, 16'd2, 4'd0), acc, rdy);
    cycle(1'b1, 2'd1, 1'b0, 16'd7, 16'd3, 4'd0, 1'b0, model(2'd1, 1'b0, 16'd7, 16'd3, 4'd0), acc, rdy);
    cycle(1'b0, 2'd0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, zero_e, acc, rdy);
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL full_before_reset: in_ready=%b want 0", rdy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || ALU_out !== 16'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midstream_reset: v=%b out=%h ovf=%b rdy=%b want 0 0000 0 1", out_valid, ALU_out, overflow, in_ready);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start = emitted;
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, zero_e, acc, rdy);
    total++;
    if (emitted != start) begin
      bad++;
      $display("FAIL discarded_beats: %0d beats emitted after reset want 0", emitted - start);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
